// File: rtl/page_writeback_pkg.sv
// page_writeback_pkg
// Shared definitions for the paging path: the write-back engine, the BIOS
// page loader and the paging memory all agree on page geometry through
// these defaults.
//   PAGE_WORDS_DEF   words per page (power of two, 2..256)
//   PID_W_DEF        width of a process identifier
//   wb_state_t       write-back FSM state encoding
//   page_base_addr() first paging-memory word of a process's page
package page_writeback_pkg;

    localparam int unsigned PAGE_WORDS_DEF = 32;
    localparam int unsigned PID_W_DEF      = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } wb_state_t;

    // A page occupies PID*PAGE_WORDS .. PID*PAGE_WORDS+PAGE_WORDS-1, so the
    // base is the PID shifted above the in-page offset bits.
    function automatic logic [31:0] page_base_addr(input logic [31:0] pid,
                                                   input int unsigned off_w);
        return pid << off_w;
    endfunction

endpackage

// File: rtl/page_writeback_addr_gen.sv
// wb_addr_gen
// Address side of the write-back engine: holds the latched PID and HD base,
// the in-page offset counter and the registered PageAddr / HD_Index values.
// The FSM in page_writeback tells it which phase it is in.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        accept strobe: latch pid/hd_base, clear offset, read word 0
//   prime       PRIME cycle: first write index, read word 1
//   step        STREAM cycle that is not the last word: advance offset
//   pid         process id (sampled only on load)
//   hd_base     HD slot base index (sampled only on load)
//   last        current write offset is the last word of the page
//   page_addr   registered paging-memory read address
//   hd_index    registered HD write index
module wb_addr_gen
    import page_writeback_pkg::*;
#(
    parameter int unsigned PAGE_WORDS = PAGE_WORDS_DEF,
    parameter int unsigned PID_W      = PID_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             prime,
    input  logic             step,
    input  logic [PID_W-1:0] pid,
    input  logic [31:0]      hd_base,
    output logic             last,
    output logic [31:0]      page_addr,
    output logic [31:0]      hd_index
);

    localparam int unsigned      OFF_W        = $clog2(PAGE_WORDS);
    localparam logic [OFF_W-1:0] OFF_LAST     = OFF_W'(PAGE_WORDS - 1);
    localparam logic [OFF_W-1:0] OFF_PRE_LAST = OFF_W'(PAGE_WORDS - 2);

    logic [PID_W-1:0] pid_q;
    logic [31:0]      base_q;
    logic [OFF_W-1:0] offset_q;

    logic [OFF_W-1:0] offset_inc;
    logic [OFF_W-1:0] offset_ahead;
    logic [31:0]      pid_ext_in;
    logic [31:0]      pid_ext_q;
    logic [31:0]      off_inc_ext;
    logic [31:0]      off_ahead_ext;

    // offset_q is the word being written this cycle; the read address runs
    // one word ahead of it, so the next write index is offset+1 and the next
    // read address is offset+2.
    always_comb begin
        offset_inc    = offset_q + OFF_W'(1);
        offset_ahead  = offset_q + OFF_W'(2);
        pid_ext_in    = '0;
        pid_ext_in[PID_W-1:0] = pid;
        pid_ext_q     = '0;
        pid_ext_q[PID_W-1:0]  = pid_q;
        off_inc_ext   = '0;
        off_inc_ext[OFF_W-1:0] = offset_inc;
        off_ahead_ext = '0;
        off_ahead_ext[OFF_W-1:0] = offset_ahead;
    end

    assign last = (offset_q == OFF_LAST);

    // The page base has its low OFF_W bits clear, so OR-ing the offset in
    // gives the zero-extended {PID, offset} address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pid_q     <= '0;
            base_q    <= '0;
            offset_q  <= '0;
            page_addr <= '0;
            hd_index  <= '0;
        end else if (load) begin
            pid_q     <= pid;
            base_q    <= hd_base;
            offset_q  <= '0;
            page_addr <= page_base_addr(pid_ext_in, OFF_W);
            hd_index  <= '0;
        end else if (prime) begin
            hd_index  <= base_q;
            page_addr <= page_base_addr(pid_ext_q, OFF_W) | off_inc_ext;
        end else if (step) begin
            offset_q <= offset_inc;
            // HD index wraps modulo 2^32 by plain 32-bit addition.
            hd_index <= base_q + off_inc_ext;
            // When the next write is the last word, the read address stays
            // on that word so nothing past the page is ever addressed.
            if (offset_q != OFF_PRE_LAST) begin
                page_addr <= page_base_addr(pid_ext_q, OFF_W) | off_ahead_ext;
            end
        end else begin
            offset_q  <= '0;
            page_addr <= '0;
            hd_index  <= '0;
        end
    end

endmodule

// File: rtl/page_writeback.sv
// page_writeback
// Copies one process page from paging memory back into the HD on a context
// switch (reverse of the BIOS page loader).
// Ports:
//   Clock, Reset   system clock, asynchronous active-high reset
//   Start, PID, HD_Base   request; sampled only in IDLE
//   PageAddr       paging-memory read address (registered)
//   PageData       paging-memory read data for the address presented in the
//                  current cycle; captured at the closing edge of that cycle
//   HD_Index, HD_WriteData, HD_wr   HD write port, one word per HD_wr cycle
//   Busy, Done     status
//   state_dbg      current FSM state (wb_state_t encoding)
//
// Handshake: Start is a level request looked at only in IDLE; there is no
// ready and no queueing. Accept happens at the edge where IDLE sees
// Start=1. Busy is high for PRIME and STREAM, then Done pulses for exactly
// one cycle (FINISH) with Busy low; the next request can be accepted at the
// end of the following IDLE cycle.
module page_writeback
    import page_writeback_pkg::*;
#(
    parameter int unsigned PAGE_WORDS = PAGE_WORDS_DEF,
    parameter int unsigned PID_W      = PID_W_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PID_W-1:0] PID,
    input  logic [31:0]      HD_Base,
    output logic [31:0]      PageAddr,
    input  logic [31:0]      PageData,
    output logic [31:0]      HD_Index,
    output logic [31:0]      HD_WriteData,
    output logic             HD_wr,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       state_dbg
);

    wb_state_t state;
    wb_state_t next_state;

    logic        last_word;
    logic        accept;
    logic        prime;
    logic        step;

    logic        busy_d;
    logic        done_d;
    logic        hd_wr_d;
    logic [31:0] wdata_d;

    assign accept = (state == IDLE) && Start;
    assign prime  = (state == PRIME);
    assign step   = (state == STREAM) && !last_word;

    wb_addr_gen #(
        .PAGE_WORDS (PAGE_WORDS),
        .PID_W      (PID_W)
    ) u_addr_gen (
        .clk       (Clock),
        .rst       (Reset),
        .load      (accept),
        .prime     (prime),
        .step      (step),
        .pid       (PID),
        .hd_base   (HD_Base),
        .last      (last_word),
        .page_addr (PageAddr),
        .hd_index  (HD_Index)
    );

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Start) next_state = PRIME;
            PRIME:   next_state = STREAM;
            STREAM:  if (last_word) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: decoded from the state being entered so every output is
    // a flop that lines up with the state it belongs to.
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        hd_wr_d = 1'b0;
        wdata_d = '0;
        case (next_state)
            PRIME: begin
                busy_d = 1'b1;
            end
            STREAM: begin
                busy_d  = 1'b1;
                hd_wr_d = 1'b1;
                wdata_d = PageData;
            end
            FINISH: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Busy         <= 1'b0;
            Done         <= 1'b0;
            HD_wr        <= 1'b0;
            HD_WriteData <= '0;
        end else begin
            Busy         <= busy_d;
            Done         <= done_d;
            HD_wr        <= hd_wr_d;
            HD_WriteData <= wdata_d;
        end
    end

    assign state_dbg = 2'(state);

endmodule

// File: tb/tb_page_writeback.sv
module tb_page_writeback;
    import page_writeback_pkg::*;

    localparam int unsigned PW   = 32;
    localparam int unsigned PIDW = 5;

    logic            clk;
    logic            rst;
    logic            start;
    logic [PIDW-1:0] pid;
    logic [31:0]     hd_base;
    logic [31:0]     page_addr;
    logic [31:0]     page_data;
    logic [31:0]     hd_index;
    logic [31:0]     hd_wdata;
    logic            hd_wr;
    logic            busy;
    logic            done;
    logic [1:0]      state_dbg;

    logic [63:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Paging memory: each word holds 0xA000_0000 + its address.
    assign page_data = 32'hA000_0000 + page_addr;

    page_writeback #(
        .PAGE_WORDS (PW),
        .PID_W      (PIDW)
    ) dut (
        .Clock        (clk),
        .Reset        (rst),
        .Start        (start),
        .PID          (pid),
        .HD_Base      (hd_base),
        .PageAddr     (page_addr),
        .PageData     (page_data),
        .HD_Index     (hd_index),
        .HD_WriteData (hd_wdata),
        .HD_wr        (hd_wr),
        .Busy         (busy),
        .Done         (done),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [63:0] exp;
        if (rst === 1'b0) begin
            if (hd_wr === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got idx=%h data=%h with empty queue", hd_index, hd_wdata);
                end else begin
                    exp = exp_q.pop_front();
                    if ({hd_index, hd_wdata} !== exp) begin
                        failures++;
                        $display("FAIL hd_write got idx=%h data=%h exp idx=%h data=%h",
                                 hd_index, hd_wdata, exp[63:32], exp[31:0]);
                    end
                end
            end else begin
                checks++;
                if (hd_wr !== 1'b0 || hd_index !== 32'd0 || hd_wdata !== 32'd0) begin
                    failures++;
                    $display("FAIL idle_write_port got wr=%b idx=%h data=%h exp 0/0/0", hd_wr, hd_index, hd_wdata);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_expected(input logic [31:0] p, input logic [31:0] base, input int n);
        logic [31:0] idx;
        logic [31:0] dat;
        for (int i = 0; i < n; i++) begin
            idx = base + 32'(i);
            dat = 32'hA000_0000 + p * PW + 32'(i);
            exp_q.push_back({idx, dat});
        end
    endtask

    // Waits (bounded) for Done, counting negedges and HD write cycles.
    task automatic wait_done(input bit drop_start, output int cycles, output int writes);
        cycles = 0;
        writes = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (drop_start && cycles == 1) start = 1'b0;
            if (hd_wr === 1'b1) writes++;
        end while (done !== 1'b1 && cycles < 200);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pid = '0; hd_base = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({page_addr, hd_index, hd_wdata} !== 96'd0) begin
            failures++;
            $display("FAIL reset_data got addr=%h idx=%h data=%h exp 0", page_addr, hd_index, hd_wdata);
        end
        checks++;
        if ({hd_wr, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl got wr/busy/done=%b exp 000", {hd_wr, busy, done});
        end
        checks++;
        if (state_dbg !== IDLE) begin
            failures++;
            $display("FAIL reset_state got %0d exp %0d", state_dbg, IDLE);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || state_dbg !== IDLE) begin
            failures++;
            $display("FAIL reset_release got busy=%b state=%0d exp 0/IDLE", busy, state_dbg);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_addr;
        push_expected(3, 32'h100, PW);
        pid = 5'd3; hd_base = 32'h100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || hd_wr !== 1'b0 || page_addr !== 32'd96 || state_dbg !== PRIME) begin
            failures++;
            $display("FAIL basic_prime got busy=%b wr=%b addr=%0d state=%0d exp 1/0/96/PRIME",
                     busy, hd_wr, page_addr, state_dbg);
        end
        for (int i = 0; i < PW; i++) begin
            @(negedge clk);
            exp_addr = 32'd96 + 32'((i + 1 < PW) ? i + 1 : PW - 1);
            checks++;
            if (hd_wr !== 1'b1 || busy !== 1'b1 || page_addr !== exp_addr) begin
                failures++;
                $display("FAIL basic_stream[%0d] got wr=%b busy=%b addr=%0d exp 1/1/%0d",
                         i, hd_wr, busy, page_addr, exp_addr);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || hd_wr !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_t34 got done=%b busy=%b wr=%b exp 1/0/0", done, busy, hd_wr);
        end
        start = 1'b1;  // seen only by the edge that ends FINISH
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || state_dbg !== IDLE) begin
            failures++;
            $display("FAIL basic_start_in_finish got done=%b busy=%b state=%0d exp 0/0/IDLE",
                     done, busy, state_dbg);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_end got busy=%b queue=%0d exp 0/0", busy, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int cyc, wr;
        push_expected(1, 32'h200, PW);
        push_expected(1, 32'h200, PW);
        pid = 5'd1; hd_base = 32'h200; start = 1'b1;
        wait_done(1'b0, cyc, wr);
        checks++;
        if (cyc != PW + 2 || wr != PW) begin
            failures++;
            $display("FAIL b2b_first got cycles=%0d writes=%0d exp %0d/%0d", cyc, wr, PW + 2, PW);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== IDLE) begin
            failures++;
            $display("FAIL b2b_gap got busy=%b done=%b state=%0d exp 0/0/IDLE", busy, done, state_dbg);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || state_dbg !== PRIME) begin
            failures++;
            $display("FAIL b2b_restart got busy=%b state=%0d exp 1/PRIME", busy, state_dbg);
        end
        start = 1'b0;
        wait_done(1'b0, cyc, wr);
        checks++;
        if (cyc != PW + 1 || wr != PW) begin
            failures++;
            $display("FAIL b2b_second got cycles=%0d writes=%0d exp %0d/%0d", cyc, wr, PW + 1, PW);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_end got busy=%b queue=%0d exp 0/0", busy, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int cyc, wr;
        push_expected(0, 32'hFFFF_FFF0, PW);
        pid = 5'd0; hd_base = 32'hFFFF_FFF0; start = 1'b1;
        wait_done(1'b1, cyc, wr);
        checks++;
        if (cyc != PW + 2 || wr != PW) begin
            failures++;
            $display("FAIL wrap_len got cycles=%0d writes=%0d exp %0d/%0d", cyc, wr, PW + 2, PW);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_queue got %0d left exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc, wr;
        push_expected(2, 32'h300, 9);
        pid = 5'd2; hd_base = 32'h300; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (hd_wr !== 1'b0) begin
            failures++;
            $display("FAIL midreset_wr got %b exp 0", hd_wr);
        end
        checks++;
        if ({page_addr, hd_index, hd_wdata} !== 96'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got addr=%h idx=%h data=%h busy=%b done=%b exp all 0",
                     page_addr, hd_index, hd_wdata, busy, done);
        end
        @(negedge clk);
        checks++;
        if (state_dbg !== IDLE) begin
            failures++;
            $display("FAIL midreset_state got %0d exp IDLE", state_dbg);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || hd_wr !== 1'b0) begin
            failures++;
            $display("FAIL midreset_partial got queue=%0d wr=%b exp 0/0", exp_q.size(), hd_wr);
        end
        push_expected(2, 32'h300, PW);
        start = 1'b1;
        wait_done(1'b1, cyc, wr);
        checks++;
        if (cyc != PW + 2 || wr != PW) begin
            failures++;
            $display("FAIL midreset_rerun got cycles=%0d writes=%0d exp %0d/%0d", cyc, wr, PW + 2, PW);
        end
        @(negedge clk);
    endtask

    task automatic test_input_change();
        int cyc;
        push_expected(5, 32'h400, PW);
        pid = 5'd5; hd_base = 32'h400; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) begin
                checks++;
                if (page_addr < 32'd160 || page_addr > 32'd191) begin
                    failures++;
                    $display("FAIL latch_addr got %0d exp 160..191", page_addr);
                end
            end
            pid = PIDW'($urandom_range(0, 31));
            hd_base = $urandom();
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != PW + 1) begin
            failures++;
            $display("FAIL latch_len got %0d exp %0d", cyc, PW + 1);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL latch_queue got %0d left exp 0", exp_q.size());
        end
    endtask

    task automatic test_pid31();
        int cyc;
        logic [31:0] last_addr;
        logic [31:0] max_addr;
        push_expected(31, 32'h0, PW);
        pid = 5'd31; hd_base = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; last_addr = '0; max_addr = '0;
        while (done !== 1'b1 && cyc < 200) begin
            if (page_addr > max_addr) max_addr = page_addr;
            if (hd_wr === 1'b1) last_addr = page_addr;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (last_addr !== 32'd1023) begin
            failures++;
            $display("FAIL pid31_last got %0d exp 1023", last_addr);
        end
        checks++;
        if (max_addr !== 32'd1023) begin
            failures++;
            $display("FAIL pid31_max got %0d exp 1023", max_addr);
        end
        checks++;
        if (cyc != PW + 1) begin
            failures++;
            $display("FAIL pid31_len got %0d exp %0d", cyc, PW + 1);
        end
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_input_change();
        test_pid31();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_queue got %0d left exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
